// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_pkg
// Brief    : Shared constants, region enum and address decode helper for the
//            CPU data-bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_bus_pkg;

    localparam logic [7:0] OFF_COUNT      = 8'h00;
    localparam logic [7:0] OFF_CTRL       = 8'h04;
    localparam logic [7:0] OFF_ERR_STATUS = 8'h08;
    localparam logic [7:0] OFF_ERR_ADDR   = 8'h0C;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_UNMAPPED = 1;

    localparam logic [31:0] ERR_READ_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        RAM        = 2'd0,
        MMIO       = 2'd1,
        UNMAPPED   = 2'd2,
        MISALIGNED = 2'd3
    } region_t;

    // Alignment is checked first so a misaligned access never also counts as unmapped.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input int unsigned depth_log2,
        input logic [23:0] mmio_page
    );
        if (addr[1:0] != 2'b00)
            return MISALIGNED;
        else if ((addr >> (depth_log2 + 2)) == 32'd0)
            return RAM;
        else if (addr[31:8] == mmio_page)
            return MMIO;
        else
            return UNMAPPED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Brief    : Single-port synchronous word RAM with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge CLK) begin
        if (we)
            r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_responder
// Brief    : Data-bus slave: word RAM plus an MMIO page holding a cycle
//            counter, its control register and sticky bus-error capture.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        err_flag
);

    region_t     w_region;
    logic [7:0]  w_offset;
    logic        w_rd;
    logic        w_wr;
    logic        w_ram_we;
    logic        w_mmio_wr;
    logic        w_ctrl_wr;
    logic [1:0]  w_err_set;
    logic [1:0]  w_err_w1c;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_ram_rdata;

    logic [31:0] r_count;
    logic        r_enable;
    logic [1:0]  r_err_status;
    logic [31:0] r_err_addr;
    logic [31:0] r_hold;
    logic        r_ram_pending;

    assign w_region  = decode_region(ADDR, DEPTH_LOG2, MMIO_BASE[31:8]);
    assign w_offset  = ADDR[7:0];
    assign w_rd      = CS & ~WR_RD;
    assign w_wr      = CS &  WR_RD;
    assign w_ram_we  = w_wr & (w_region == RAM) & ~reset;
    assign w_mmio_wr = w_wr & (w_region == MMIO);
    assign w_ctrl_wr = w_mmio_wr & (w_offset == OFF_CTRL);

    always_comb begin
        w_err_set = 2'b00;
        w_err_set[ERR_MISALIGN] = CS & (w_region == MISALIGNED);
        w_err_set[ERR_UNMAPPED] = CS & (w_region == UNMAPPED);
    end

    assign w_err_w1c = (w_mmio_wr && (w_offset == OFF_ERR_STATUS)) ?
                       Data_BUS_WRITE[1:0] : 2'b00;

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dmem_ram (
        .CLK   (CLK),
        .we    (w_ram_we),
        .addr  (ADDR[DEPTH_LOG2+1:2]),
        .wdata (Data_BUS_WRITE),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_offset)
            OFF_COUNT:      w_mmio_rdata = r_count;
            OFF_CTRL:       w_mmio_rdata[CTRL_EN] = r_enable;
            OFF_ERR_STATUS: w_mmio_rdata[1:0] = r_err_status;
            OFF_ERR_ADDR:   w_mmio_rdata = r_err_addr;
            default:        w_mmio_rdata = 32'd0;
        endcase
    end

    // Counter clear beats increment; enable change applies from the next edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_count  <= 32'd0;
            r_enable <= 1'b1;
        end else begin
            if (w_ctrl_wr && Data_BUS_WRITE[CTRL_CLR])
                r_count <= 32'd0;
            else if (r_enable)
                r_count <= r_count + 32'd1;
            if (w_ctrl_wr)
                r_enable <= Data_BUS_WRITE[CTRL_EN];
        end
    end

    // A freshly detected error wins over a simultaneous write-1-to-clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_err_status <= 2'b00;
            r_err_addr   <= 32'd0;
        end else begin
            r_err_status <= (r_err_status & ~w_err_w1c) | w_err_set;
            if (|w_err_set)
                r_err_addr <= ADDR;
        end
    end

    // RAM data arrives from the RAM's own output register; it is copied into
    // r_hold on the following edge so the bus value survives idle cycles.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_hold        <= 32'd0;
            r_ram_pending <= 1'b0;
        end else if (w_rd && (w_region == RAM)) begin
            r_ram_pending <= 1'b1;
        end else begin
            r_ram_pending <= 1'b0;
            if (w_rd && (w_region == MMIO))
                r_hold <= w_mmio_rdata;
            else if (w_rd)
                r_hold <= ERR_READ_DATA;
            else if (r_ram_pending)
                r_hold <= w_ram_rdata;
        end
    end

    assign Data_BUS_READ = r_ram_pending ? w_ram_rdata : r_hold;
    assign err_flag      = |r_err_status;

endmodule
`default_nettype wire
